reset_boot_ctrl: RTL and testbench
==================================

RESET_BOOT_CTRL -- requirements
Module: reset_boot_ctrl

Interface
REQ-001 SHALL have parameter SS_COUNT, default 4: number of subsystem reset outputs (1..8).
REQ-002 SHALL have parameter STAGE_DELAY, default 8: cycles between consecutive reset releases (1..255).
REQ-003 SHALL have parameter SYNC_STAGES, default 2: reset synchronizer depth (2..4).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024: fetch-wait limit, used only under BOOT_TIMEOUT_EN.
REQ-005 SHALL have port clk_in, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port boot_sel, input, 1: boot source pin, asynchronous.
REQ-008 SHALL have port fetch_en, input, 1: fetch enable pin, asynchronous.
REQ-009 SHALL have port sw_rst_req, input, 1: single-cycle soft-reset request from the control register block.
REQ-010 SHALL have port sys_rst_n, output, 1: interconnect and peripheral reset, active-low.
REQ-011 SHALL have port ss_rst_n, output, SS_COUNT: per-subsystem resets, active-low.
REQ-012 SHALL have port core_rst_n, output, 1: CPU reset, active-low.
REQ-013 SHALL have port boot_sel_q, output, 1: latched boot source.
REQ-014 SHALL have port core_fetch_en, output, 1: CPU fetch enable.
REQ-015 SHALL have port boot_done, output, 1: high in RUN.
REQ-016 SHALL have port boot_timeout, output, 1: sticky fetch-wait timeout flag.

Function
REQ-017 SHALL assert reset asynchronously to all flops and deassert it internally only after SYNC_STAGES clk_in edges.
REQ-018 SHALL sequence the states IDLE, SYS_REL, SS_REL, CORE_REL, WAIT_FETCH and RUN.
REQ-019 SHALL run a stage counter from 0 to STAGE_DELAY-1 in SYS_REL, SS_REL and CORE_REL; reaching the terminal count completes that stage.
REQ-020 SHALL leave IDLE for SYS_REL on the first cycle the synchronized reset is high.
REQ-021 SHALL, at SYS_REL terminal count, drive sys_rst_n high on the next cycle and enter SS_REL with index 0.
REQ-022 SHALL, at each SS_REL terminal count, drive ss_rst_n[index] high on the next cycle, increment the index and restart the counter.
REQ-023 SHALL go from SS_REL to CORE_REL after index SS_COUNT-1 and latch the synchronized boot_sel into boot_sel_q on that transition.
REQ-024 SHALL, at CORE_REL terminal count, drive core_rst_n high on the next cycle and enter WAIT_FETCH.
REQ-025 SHALL therefore raise core_rst_n (SS_COUNT+2)*STAGE_DELAY cycles after the synchronized reset goes high.
REQ-026 SHALL synchronize fetch_en and boot_sel through two flops each.
REQ-027 SHALL, in WAIT_FETCH, on synchronized fetch_en high, set core_fetch_en and boot_done on the next cycle and enter RUN.
REQ-028 SHALL hold core_fetch_en high in RUN regardless of fetch_en.
REQ-029 SHALL, on sw_rst_req in WAIT_FETCH or RUN, drive all ss_rst_n, core_rst_n, core_fetch_en and boot_done low on the next cycle, keep sys_rst_n high, and re-enter SS_REL at index 0.
REQ-030 SHALL ignore sw_rst_req in IDLE, SYS_REL, SS_REL and CORE_REL.
REQ-031 SHALL give sw_rst_req priority over fetch_en when both arrive in the same WAIT_FETCH cycle.
REQ-032 SHALL keep boot_sel_q constant except when passing through the CORE_REL transition.

Reset
REQ-033 SHALL, while reset is low, hold sys_rst_n, ss_rst_n, core_rst_n, core_fetch_en, boot_done, boot_sel_q and boot_timeout at 0, the state in IDLE, and the counter and index at 0.
REQ-034 SHALL return to these values immediately when reset is asserted mid-sequence, from any state.

Configuration
REQ-035 SHALL, with macro RESET_BOOT_CTRL_TIMEOUT_EN defined, count cycles in WAIT_FETCH and set boot_timeout one cycle after TIMEOUT_CYCLES is reached.
REQ-036 SHALL, in that timeout case, stay in WAIT_FETCH, keep boot_timeout set until reset, and clear the count on a WAIT_FETCH exit.
REQ-037 SHALL, without RESET_BOOT_CTRL_TIMEOUT_EN, tie boot_timeout to 0 and build no timeout counter.

Structure
REQ-038 SHALL place the state enum, parameter defaults and the counter width constant in package didactic_rst_pkg.
REQ-039 SHALL implement the reset synchronizer as sub-module rst_sync, parameterized by SYNC_STAGES.

Verification
REQ-040 SHALL check power-on release with SS_COUNT=4, STAGE_DELAY=8: reset rises, then after sync sys_rst_n rises at 8, ss_rst_n[0..3] at 16/24/32/40, and core_rst_n at 48 cycles.
REQ-041 SHALL check boot latching: boot_sel=1 during SS_REL then 0 in RUN -> boot_sel_q stays 1.
REQ-042 SHALL check fetch gating: fetch_en high 10 cycles after core_rst_n, then low -> core_fetch_en rises within 3 cycles and stays 1.
REQ-043 SHALL check soft reset: sw_rst_req pulse in RUN -> ss_rst_n=0, core_rst_n=0, sys_rst_n=1 next cycle, then re-release 8 cycles apart.
REQ-044 SHALL check mid-sequence reset: reset low during SS_REL index 2 -> all outputs 0 asynchronously, and a full sequence restarts on release.
REQ-045 SHALL check timeout with RESET_BOOT_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, fetch_en held low -> boot_timeout=1 at 17 cycles after core_rst_n.

Source files
------------

// File: rtl/didactic_rst_pkg.sv
// Shared types and constants for the reset/boot sequencer.
// The optional fetch-wait watchdog is enabled with RESET_BOOT_CTRL_TIMEOUT_EN.
package didactic_rst_pkg;

   localparam int SS_COUNT_DEF       = 4;
   localparam int STAGE_DELAY_DEF    = 8;
   localparam int SYNC_STAGES_DEF    = 2;
   localparam int TIMEOUT_CYCLES_DEF = 1024;

   // Wide enough for any STAGE_DELAY up to 255
   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SYS_REL    = 3'd1,
      ST_SS_REL     = 3'd2,
      ST_CORE_REL   = 3'd3,
      ST_WAIT_FETCH = 3'd4,
      ST_RUN        = 3'd5
   } boot_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases after SYNC_STAGES clock edges.
module rst_sync
   import didactic_rst_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk_in,
   input  logic i_rst_n,
   output logic o_rst_n
);

   logic [SYNC_STAGES-1:0] r_sync;

   // Shift ones in after release; any low on i_rst_n clears the chain at once
   always_ff @(posedge clk_in or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign o_rst_n = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/reset_boot_ctrl.sv
// Staged reset release (system, subsystems, core) followed by fetch gating.
// Define RESET_BOOT_CTRL_TIMEOUT_EN to build the sticky fetch-wait timeout.
module reset_boot_ctrl
   import didactic_rst_pkg::*;
#(
   parameter int SS_COUNT       = SS_COUNT_DEF,
   parameter int STAGE_DELAY    = STAGE_DELAY_DEF,
   parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                clk_in,
   input  logic                reset,
   input  logic                boot_sel,
   input  logic                fetch_en,
   input  logic                sw_rst_req,
   output logic                sys_rst_n,
   output logic [SS_COUNT-1:0] ss_rst_n,
   output logic                core_rst_n,
   output logic                boot_sel_q,
   output logic                core_fetch_en,
   output logic                boot_done,
   output logic                boot_timeout
);

   localparam int               IDX_W    = idx_width(SS_COUNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_DELAY - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SS_COUNT - 1);

   logic                w_rst_n;
   logic [1:0]          r_boot_sync;
   logic [1:0]          r_fetch_sync;
   logic                w_boot_sel_s;
   logic                w_fetch_en_s;
   logic                w_stage_done;
   logic                w_soft_rst;
   boot_state_t         r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [IDX_W-1:0]    r_idx;
   logic                r_sys_rst_n;
   logic [SS_COUNT-1:0] r_ss_rst_n;
   logic                r_core_rst_n;
   logic                r_boot_sel_q;
   logic                r_core_fetch_en;
   logic                r_boot_done;

   rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
      .clk_in  (clk_in),
      .i_rst_n (reset),
      .o_rst_n (w_rst_n)
   );

   // Two-flop synchronizers for the asynchronous boot pins
   always_ff @(posedge clk_in or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_boot_sync  <= 2'b00;
         r_fetch_sync <= 2'b00;
      end else begin
         r_boot_sync  <= {r_boot_sync[0], boot_sel};
         r_fetch_sync <= {r_fetch_sync[0], fetch_en};
      end
   end

   assign w_boot_sel_s = r_boot_sync[1];
   assign w_fetch_en_s = r_fetch_sync[1];
   assign w_stage_done = (r_cnt == CNT_LAST);
   // Soft reset only acts once the core has been released
   assign w_soft_rst   = sw_rst_req && ((r_state == ST_WAIT_FETCH) || (r_state == ST_RUN));

   // Release sequencer; every output is a register updated here
   always_ff @(posedge clk_in or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state         <= ST_IDLE;
         r_cnt           <= '0;
         r_idx           <= '0;
         r_sys_rst_n     <= 1'b0;
         r_ss_rst_n      <= '0;
         r_core_rst_n    <= 1'b0;
         r_boot_sel_q    <= 1'b0;
         r_core_fetch_en <= 1'b0;
         r_boot_done     <= 1'b0;
      end else if (w_soft_rst) begin
         r_ss_rst_n      <= '0;
         r_core_rst_n    <= 1'b0;
         r_core_fetch_en <= 1'b0;
         r_boot_done     <= 1'b0;
         r_cnt           <= '0;
         r_idx           <= '0;
         r_state         <= ST_SS_REL;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cnt   <= '0;
               r_state <= ST_SYS_REL;
            end
            ST_SYS_REL: begin
               if (w_stage_done) begin
                  r_sys_rst_n <= 1'b1;
                  r_cnt       <= '0;
                  r_idx       <= '0;
                  r_state     <= ST_SS_REL;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_SS_REL: begin
               if (w_stage_done) begin
                  r_ss_rst_n[r_idx] <= 1'b1;
                  r_cnt             <= '0;
                  if (r_idx == IDX_LAST) begin
                     r_boot_sel_q <= w_boot_sel_s;
                     r_state      <= ST_CORE_REL;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_CORE_REL: begin
               if (w_stage_done) begin
                  r_core_rst_n <= 1'b1;
                  r_cnt        <= '0;
                  r_state      <= ST_WAIT_FETCH;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_WAIT_FETCH: begin
               if (w_fetch_en_s) begin
                  r_core_fetch_en <= 1'b1;
                  r_boot_done     <= 1'b1;
                  r_state         <= ST_RUN;
               end else begin
                  r_state <= ST_WAIT_FETCH;
               end
            end
            ST_RUN: begin
               r_state <= ST_RUN;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef RESET_BOOT_CTRL_TIMEOUT_EN
   localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES);

   logic [TO_W-1:0] r_to_cnt;
   logic            r_boot_timeout;

   // Fetch-wait watchdog; count saturates and the flag stays set until reset
   always_ff @(posedge clk_in or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_to_cnt       <= '0;
         r_boot_timeout <= 1'b0;
      end else if ((r_state != ST_WAIT_FETCH) || w_soft_rst || w_fetch_en_s) begin
         r_to_cnt <= '0;
      end else if (r_to_cnt == TO_LAST) begin
         r_boot_timeout <= 1'b1;
      end else begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   assign boot_timeout = r_boot_timeout;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES == 32'sd0);
   assign boot_timeout     = 1'b0;
`endif

   assign sys_rst_n     = r_sys_rst_n;
   assign ss_rst_n      = r_ss_rst_n;
   assign core_rst_n    = r_core_rst_n;
   assign boot_sel_q    = r_boot_sel_q;
   assign core_fetch_en = r_core_fetch_en;
   assign boot_done     = r_boot_done;

endmodule

// File: tb/tb_reset_boot_ctrl.sv
// Directed bench for reset_boot_ctrl (SS_COUNT=4, STAGE_DELAY=8, SYNC_STAGES=2, TIMEOUT_CYCLES=16).
// Edge numbers count rising edges after reset release: sync high after edge 2, SYS_REL entered at edge 3.
module tb_reset_boot_ctrl;

   logic       clk_in     = 1'b0;
   logic       reset      = 1'b1;
   logic       boot_sel   = 1'b0;
   logic       fetch_en   = 1'b0;
   logic       sw_rst_req = 1'b0;
   logic       sys_rst_n;
   logic [3:0] ss_rst_n;
   logic       core_rst_n;
   logic       boot_sel_q;
   logic       core_fetch_en;
   logic       boot_done;
   logic       boot_timeout;

   int checks = 0;
   int errors = 0;

`ifdef RESET_BOOT_CTRL_TIMEOUT_EN
   localparam logic TO_EXP = 1'b1;
`else
   localparam logic TO_EXP = 1'b0;
`endif

   always #5 clk_in = ~clk_in;

   reset_boot_ctrl #(
      .SS_COUNT       (4),
      .STAGE_DELAY    (8),
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_in        (clk_in),
      .reset         (reset),
      .boot_sel      (boot_sel),
      .fetch_en      (fetch_en),
      .sw_rst_req    (sw_rst_req),
      .sys_rst_n     (sys_rst_n),
      .ss_rst_n      (ss_rst_n),
      .core_rst_n    (core_rst_n),
      .boot_sel_q    (boot_sel_q),
      .core_fetch_en (core_fetch_en),
      .boot_done     (boot_done),
      .boot_timeout  (boot_timeout)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_low(input string tag);
      chk({tag, "_sys"},   {7'd0, sys_rst_n},     8'h00);
      chk({tag, "_ss"},    {4'd0, ss_rst_n},      8'h00);
      chk({tag, "_core"},  {7'd0, core_rst_n},    8'h00);
      chk({tag, "_bsq"},   {7'd0, boot_sel_q},    8'h00);
      chk({tag, "_fetch"}, {7'd0, core_fetch_en}, 8'h00);
      chk({tag, "_done"},  {7'd0, boot_done},     8'h00);
      chk({tag, "_to"},    {7'd0, boot_timeout},  8'h00);
   endtask

   initial begin
      #1 reset = 1'b0;
      step(3);
      chk_all_low("por");

      // Power-on release with boot_sel high during the subsystem stages
      boot_sel = 1'b1;
      reset    = 1'b1;
      step(10); chk("sys_e10",  {7'd0, sys_rst_n}, 8'h00);
      step(1);  chk("sys_e11",  {7'd0, sys_rst_n}, 8'h01);
                chk("ss_e11",   {4'd0, ss_rst_n},  8'h00);
      step(7);  chk("ss_e18",   {4'd0, ss_rst_n},  8'h00);
      step(1);  chk("ss_e19",   {4'd0, ss_rst_n},  8'h01);
      step(8);  chk("ss_e27",   {4'd0, ss_rst_n},  8'h03);
      step(8);  chk("ss_e35",   {4'd0, ss_rst_n},  8'h07);
      step(7);  chk("bsq_e42",  {7'd0, boot_sel_q}, 8'h00);
      step(1);  chk("ss_e43",   {4'd0, ss_rst_n},  8'h0f);
                chk("bsq_e43",  {7'd0, boot_sel_q}, 8'h01);
      step(7);  chk("core_e50", {7'd0, core_rst_n}, 8'h00);
      step(1);  chk("core_e51", {7'd0, core_rst_n}, 8'h01);
                chk("fetch_e51", {7'd0, core_fetch_en}, 8'h00);

      // Fetch gating: pin raised 10 cycles after core release, two-flop sync plus one
      boot_sel = 1'b0;
      step(10);
      fetch_en = 1'b1;
      step(2);  chk("fetch_e63", {7'd0, core_fetch_en}, 8'h00);
      step(1);  chk("fetch_e64", {7'd0, core_fetch_en}, 8'h01);
                chk("done_e64",  {7'd0, boot_done},     8'h01);
      fetch_en = 1'b0;
      step(5);  chk("fetch_hold", {7'd0, core_fetch_en}, 8'h01);
                chk("bsq_run",    {7'd0, boot_sel_q},    8'h01);

      // Soft reset from RUN; edge S is the one that samples the request
      sw_rst_req = 1'b1;
      step(1);
      sw_rst_req = 1'b0;
      chk("sw_ss",    {4'd0, ss_rst_n},      8'h00);
      chk("sw_core",  {7'd0, core_rst_n},    8'h00);
      chk("sw_sys",   {7'd0, sys_rst_n},     8'h01);
      chk("sw_fetch", {7'd0, core_fetch_en}, 8'h00);
      chk("sw_done",  {7'd0, boot_done},     8'h00);
      step(7);  chk("sw_ss_s7",    {4'd0, ss_rst_n},   8'h00);
      step(1);  chk("sw_ss_s8",    {4'd0, ss_rst_n},   8'h01);
      step(24); chk("sw_ss_s32",   {4'd0, ss_rst_n},   8'h0f);
                chk("sw_bsq_s32",  {7'd0, boot_sel_q}, 8'h00);
      step(7);  chk("sw_core_s39", {7'd0, core_rst_n}, 8'h00);
      step(1);  chk("sw_core_s40", {7'd0, core_rst_n}, 8'h01);

      // Synchronized fetch_en and sw_rst_req on the same WAIT_FETCH edge (S+43 = T)
      fetch_en = 1'b1;
      step(2);
      sw_rst_req = 1'b1;
      step(1);
      sw_rst_req = 1'b0;
      fetch_en   = 1'b0;
      chk("prio_fetch", {7'd0, core_fetch_en}, 8'h00);
      chk("prio_done",  {7'd0, boot_done},     8'h00);
      chk("prio_core",  {7'd0, core_rst_n},    8'h00);

      // Request during SS_REL must not restart the sequence
      step(2);
      sw_rst_req = 1'b1;
      step(1);
      sw_rst_req = 1'b0;
      step(4);  chk("ign_t7",  {4'd0, ss_rst_n},   8'h00);
      step(1);  chk("ign_t8",  {4'd0, ss_rst_n},   8'h01);
      step(31); chk("ign_t39", {7'd0, core_rst_n}, 8'h00);
      step(1);  chk("ign_t40", {7'd0, core_rst_n}, 8'h01);

      // Fetch held low: watchdog flag one cycle after 16 counted waits
      step(16); chk("to_t56",  {7'd0, boot_timeout}, 8'h00);
      step(1);  chk("to_t57",  {7'd0, boot_timeout}, {7'd0, TO_EXP});
      step(5);  chk("to_hold", {7'd0, boot_timeout}, {7'd0, TO_EXP});

      // Soft reset from WAIT_FETCH, then hard reset during SS_REL index 2
      sw_rst_req = 1'b1;
      step(1);
      sw_rst_req = 1'b0;
      step(19); chk("mid_ss_u19", {4'd0, ss_rst_n},     8'h03);
                chk("mid_to_u19", {7'd0, boot_timeout}, {7'd0, TO_EXP});
      #1 reset = 1'b0;
      #1;
      chk_all_low("mid_async");
      step(2);
      chk_all_low("mid_hold");

      // Full restart after release
      reset = 1'b1;
      step(10); chk("re_sys_e10",  {7'd0, sys_rst_n},  8'h00);
      step(1);  chk("re_sys_e11",  {7'd0, sys_rst_n},  8'h01);
      step(32); chk("re_ss_e43",   {4'd0, ss_rst_n},   8'h0f);
      step(7);  chk("re_core_e50", {7'd0, core_rst_n}, 8'h00);
      step(1);  chk("re_core_e51", {7'd0, core_rst_n}, 8'h01);
                chk("re_bsq_e51",  {7'd0, boot_sel_q}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
